// File: rtl/bmp_header_parser.sv
// BMP header front end: copies the 54-byte header from ROM to RAM byte-for-byte,
// extracts offset/width/height, derives the padded row stride and flags unsupported formats.
module bmp_header_parser #(
   parameter int BYTE_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 20,
   parameter int HEADER_SIZE = 54
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [BYTE_WIDTH-1:0] ROM_Q,
   output logic                  ROM_ren,
   output logic [ADDR_WIDTH-1:0] ROM_addr,
   output logic                  RAM_wen,
   output logic [ADDR_WIDTH-1:0] RAM_addr,
   output logic [BYTE_WIDTH-1:0] RAM_D,
   output logic [31:0]           pix_offset,
   output logic [31:0]           img_width,
   output logic [31:0]           img_height,
   output logic [31:0]           row_stride,
   output logic [1:0]            hdr_err,
   output logic                  done
);

   typedef enum logic [2:0] {IDLE, READ, DRAIN, CHECK, DONE} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(HEADER_SIZE - 1);

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] cnt;
   logic                  vld_p1;
   logic [ADDR_WIDTH-1:0] ram_addr_p1;
   logic [7:0]            sig0, sig1;
   logic [15:0]           bpp;
   logic                  start;
   logic [7:0]            byte_q;

   // Rows are padded to a 4-byte multiple; the product is formed in 34 bits before truncation.
   function automatic logic [31:0] stride_calc(input logic [31:0] w);
      logic [33:0] t;
      t = ({2'b00, w} * 34'd3) + 34'd3;
      t[1:0] = 2'b00;
      return t[31:0];
   endfunction

   function automatic logic [1:0] err_calc(input logic [7:0] s0, input logic [7:0] s1,
                                           input logic [15:0] b, input logic [31:0] w,
                                           input logic [31:0] h);
      if (s0 != 8'h42 || s1 != 8'h4D) return 2'd1;
      if (b != 16'd24)                return 2'd2;
      if (w == 32'd0 || h == 32'd0 || h[31]) return 2'd3;
      return 2'd0;
   endfunction

   assign start  = (state_nxt == READ) && (state != READ);
   assign byte_q = ROM_Q[7:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (start)
            cnt <= '0;
         else if (state == READ && cnt != LAST_ADDR)
            cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      ROM_ren   = 1'b0;
      ROM_addr  = '0;
      done      = 1'b0;
      case (state)
         IDLE:  if (in_valid) state_nxt = READ;
         READ: begin
            ROM_ren  = 1'b1;
            ROM_addr = cnt;
            if (cnt == LAST_ADDR) state_nxt = DRAIN;
         end
         DRAIN: state_nxt = CHECK;
         CHECK: state_nxt = DONE;
         DONE: begin
            done      = 1'b1;
            state_nxt = in_valid ? READ : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // p1: ROM data returns one cycle after the read; mirror it straight into RAM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1      <= 1'b0;
         ram_addr_p1 <= '0;
      end else begin
         vld_p1      <= ROM_ren;
         ram_addr_p1 <= ROM_addr;
      end
   end

   assign RAM_wen  = vld_p1;
   assign RAM_addr = ram_addr_p1;
   assign RAM_D    = vld_p1 ? ROM_Q : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig0 <= '0; sig1 <= '0; bpp <= '0;
         pix_offset <= '0; img_width <= '0; img_height <= '0;
         row_stride <= '0; hdr_err <= '0;
      end else if (start) begin
         sig0 <= '0; sig1 <= '0; bpp <= '0;
         pix_offset <= '0; img_width <= '0; img_height <= '0;
         row_stride <= '0; hdr_err <= '0;
      end else if (vld_p1) begin
         // Little-endian fields: shift each byte in from the top
         case (ram_addr_p1[5:0])
            6'd0:                      sig0 <= byte_q;
            6'd1:                      sig1 <= byte_q;
            6'd10, 6'd11, 6'd12, 6'd13: pix_offset <= {byte_q, pix_offset[31:8]};
            6'd18, 6'd19, 6'd20, 6'd21: img_width  <= {byte_q, img_width[31:8]};
            6'd22, 6'd23, 6'd24, 6'd25: img_height <= {byte_q, img_height[31:8]};
            6'd28, 6'd29:              bpp <= {byte_q, bpp[15:8]};
            default: ;
         endcase
      end else if (state == CHECK) begin
         row_stride <= stride_calc(img_width);
         hdr_err    <= err_calc(sig0, sig1, bpp, img_width, img_height);
      end
   end

endmodule
